mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arb_starve_ctr.sv | 41 ++++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory arbiter (FSM states, port owner
// encoding) and the default starvation limit used when MEM_ARB_FAIR_EN is set.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and memory port of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline
// and memory, which drive the *_i signals.
interface mem_arbiter_if #(
  parameter int ADDR  = 32,
  parameter int W_OPR = 32
);
  logic             if_req_i;
  logic [ADDR-1:0]  if_addr_i;
  logic             if_gnt_o;
  logic             if_rvalid_o;
  logic [W_OPR-1:0] if_rdata_o;

  logic             ls_req_i;
  logic             ls_write_i;
  logic [ADDR-1:0]  ls_addr_i;
  logic [W_OPR-1:0] ls_wdata_i;
  logic             ls_gnt_o;
  logic             ls_rvalid_o;
  logic [W_OPR-1:0] ls_rdata_o;

  logic             stall_o;

  logic             mem_req_o;
  logic             mem_write_o;
  logic [ADDR-1:0]  mem_addr_o;
  logic [W_OPR-1:0] mem_wdata_o;
  logic             mem_ready_i;
  logic             mem_rvalid_i;
  logic [W_OPR-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_write_i, ls_addr_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output stall_o,
    output mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_write_i, ls_addr_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  stall_o,
    input  mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: counts consecutive contested arbitrations won by LS and
// raises force_if_o once the count reaches STARVE_LIMIT. Only compiled when
// MEM_ARB_FAIR_EN is defined.
`ifdef MEM_ARB_FAIR_EN
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_i,        // an arbitration happens this cycle
  input  logic contested_i,  // both ports were requesting
  input  logic ls_won_i,     // LS got the grant
  output logic force_if_o
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A contested LS win extends the streak; any other grant breaks it.
  // At the limit IF is forced, so the count cannot run past STARVE_LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (arb_i) begin
      if (contested_i && ls_won_i) cnt_d = cnt_q + CW'(1);
      else                         cnt_d = '0;
    end
  end

  // Streak register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign force_if_o = (cnt_q == CW'(STARVE_LIMIT));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch (IF) read port and a load/store (LS) port onto
// one memory port with at most one transaction outstanding (IDLE/REQ/RESP).
// LS wins contested arbitration; with MEM_ARB_FAIR_EN defined, IF is forced
// after STARVE_LIMIT consecutive contested LS wins (mem_arb_starve_ctr).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR         = 32,
  parameter int W_OPR        = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             write_q, write_d;
  logic [ADDR-1:0]  addr_q,  addr_d;
  logic [W_OPR-1:0] wdata_q, wdata_d;

  logic idle, any_req, contested, pick_ls, force_if;
  logic if_gnt, ls_gnt, resp_hit, if_rvalid, ls_rvalid;

  assign idle      = (state_q == ST_IDLE);
  assign any_req   = bus.if_req_i | bus.ls_req_i;
  assign contested = bus.if_req_i & bus.ls_req_i;

`ifdef MEM_ARB_FAIR_EN
  mem_arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_ctr (
    .clk         (clk),
    .reset       (reset),
    .arb_i       (idle & any_req),
    .contested_i (contested),
    .ls_won_i    (pick_ls),
    .force_if_o  (force_if)
  );
`else
  // Strict LS priority: the limit never applies (constant false for any legal limit).
  assign force_if = (STARVE_LIMIT < 0);
`endif

  assign pick_ls = bus.ls_req_i & ~(force_if & bus.if_req_i);
  assign ls_gnt  = idle & pick_ls;
  assign if_gnt  = idle & bus.if_req_i & ~pick_ls;

  // Next-state and payload capture; payload only changes on a grant in IDLE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_REQ;
          if (pick_ls) begin
            owner_d = OWN_LS;
            write_d = bus.ls_write_i;
            addr_d  = bus.ls_addr_i;
            wdata_d = bus.ls_wdata_i;
          end else begin
            owner_d = OWN_IF;
            write_d = 1'b0;
            addr_d  = bus.if_addr_i;
            wdata_d = '0;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_ready_i) state_d = write_q ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        if (bus.mem_rvalid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched transaction; reset abandons anything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Read data is only accepted while waiting in RESP; stray rvalids are dropped.
  assign resp_hit  = (state_q == ST_RESP) & bus.mem_rvalid_i;
  assign if_rvalid = resp_hit & (owner_q == OWN_IF);
  assign ls_rvalid = resp_hit & (owner_q == OWN_LS);

  assign bus.if_gnt_o    = if_gnt;
  assign bus.ls_gnt_o    = ls_gnt;
  assign bus.if_rvalid_o = if_rvalid;
  assign bus.ls_rvalid_o = ls_rvalid;
  assign bus.if_rdata_o  = if_rvalid ? bus.mem_rdata_i : '0;
  assign bus.ls_rdata_o  = ls_rvalid ? bus.mem_rdata_i : '0;

  // Stall while an LS request waits for its grant or an LS load waits for data.
  assign bus.stall_o = (bus.ls_req_i & ~ls_gnt)
                     | ((owner_q == OWN_LS) & ~write_q & ~idle & ~ls_rvalid);

  assign bus.mem_req_o   = (state_q == ST_REQ);
  assign bus.mem_write_o = write_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

endmodule
